// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
// The CPU data bus uses RW_READ/RW_WRITE from here as well.
package memory_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ACCESS  = 2'd1,
        ARB_RESPOND = 2'd2
    } arb_state_t;

    // The starvation counter needs at least one bit, even when the limit is 0.
    function automatic int starve_count_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/memory_arbiter_starve_counter.sv
// Saturating count of consecutive arbitration losses suffered by a pending fetch.
// Clear takes precedence over increment.
module starve_counter
    import memory_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_inc,
    input  logic i_clear,
    output logic o_at_limit
);

    localparam int              CW      = starve_count_width(STARVE_LIMIT);
    localparam logic [CW-1:0]   LIMIT   = CW'(STARVE_LIMIT);
    localparam bit              ENABLED = (STARVE_LIMIT != 0);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_inc && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign o_at_limit = ENABLED && (count == LIMIT);

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one single-port memory.
// Data has priority; a fetch that loses STARVE_LIMIT times in a row is forced through.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,

    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_address,
    output logic              o_fetch_ready,
    output logic [DATA_W-1:0] o_fetch_data,

    input  logic              i_data_req,
    input  logic [ADDR_W-1:0] i_data_address,
    input  logic              i_data_rw,
    input  logic [DATA_W-1:0] i_data_wdata,
    output logic              o_data_ready,
    output logic [DATA_W-1:0] o_data_rdata,

    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic              o_mem_rw,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,

    output logic [1:0]        o_debug_state,
    output logic              o_debug_grant_data
);

    arb_state_t state;
    arb_state_t state_next;
    logic       any_req;
    logic       data_wins;
    logic       at_limit;
    logic       starve_inc;
    logic       starve_clear;

    assign any_req   = i_fetch_req | i_data_req;
    assign data_wins = i_data_req & ~(i_fetch_req & at_limit);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_next   = state;
        starve_inc   = 1'b0;
        starve_clear = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    state_next = ARB_ACCESS;
                end
                // A pending fetch that loses counts up; any other IDLE edge resets the streak.
                starve_inc   = i_fetch_req & data_wins;
                starve_clear = ~(i_fetch_req & data_wins);
            end
            ARB_ACCESS: begin
                if (i_mem_ack) begin
                    state_next = ARB_RESPOND;
                end
            end
            ARB_RESPOND: state_next = ARB_IDLE;
            default:     state_next = ARB_IDLE;
        endcase
    end

    starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_inc      (starve_inc),
        .i_clear    (starve_clear),
        .o_at_limit (at_limit)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_fetch_ready      <= 1'b0;
            o_fetch_data       <= '0;
            o_data_ready       <= 1'b0;
            o_data_rdata       <= '0;
            o_mem_req          <= 1'b0;
            o_mem_address      <= '0;
            o_mem_rw           <= RW_READ;
            o_mem_wdata        <= '0;
            o_debug_grant_data <= 1'b0;
        end else begin
            o_fetch_ready <= 1'b0;
            o_data_ready  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        o_debug_grant_data <= data_wins;
                        o_mem_req          <= 1'b1;
                        o_mem_address      <= data_wins ? i_data_address : i_fetch_address;
                        o_mem_rw           <= data_wins ? i_data_rw : RW_READ;
                        o_mem_wdata        <= (data_wins && (i_data_rw == RW_WRITE)) ? i_data_wdata : '0;
                    end
                end
                ARB_ACCESS: begin
                    if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        if (o_debug_grant_data) begin
                            o_data_ready <= 1'b1;
                            o_data_rdata <= (o_mem_rw == RW_WRITE) ? '0 : i_mem_rdata;
                        end else begin
                            o_fetch_ready <= 1'b1;
                            o_fetch_data  <= i_mem_rdata;
                        end
                    end
                end
                ARB_RESPOND: begin
                end
                default: o_mem_req <= 1'b0;
            endcase
        end
    end

    assign o_debug_state = state;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, corner sequences,
// and randomized traffic against a behavioural memory/arbitration model.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int LIMIT  = 4;
    localparam int N_RAND = 40;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_fetch_req = 1'b0;
    logic [15:0] i_fetch_address = '0;
    logic        i_data_req = 1'b0;
    logic [15:0] i_data_address = '0;
    logic        i_data_rw = 1'b0;
    logic [31:0] i_data_wdata = '0;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;

    logic        o_fetch_ready, o_data_ready, o_mem_req, o_mem_rw, o_debug_grant_data;
    logic [31:0] o_fetch_data, o_data_rdata, o_mem_wdata;
    logic [15:0] o_mem_address;
    logic [1:0]  o_debug_state;

    logic        s_fetch_ready, s_data_ready, s_mem_req, s_mem_rw, s_debug_grant_data;
    logic [31:0] s_fetch_data, s_data_rdata, s_mem_wdata;
    logic [15:0] s_mem_address;
    logic [1:0]  s_debug_state;

    memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_fetch_req(i_fetch_req), .i_fetch_address(i_fetch_address),
        .o_fetch_ready(o_fetch_ready), .o_fetch_data(o_fetch_data),
        .i_data_req(i_data_req), .i_data_address(i_data_address), .i_data_rw(i_data_rw),
        .i_data_wdata(i_data_wdata), .o_data_ready(o_data_ready), .o_data_rdata(o_data_rdata),
        .o_mem_req(o_mem_req), .o_mem_address(o_mem_address), .o_mem_rw(o_mem_rw),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_debug_state(o_debug_state), .o_debug_grant_data(o_debug_grant_data)
    );

    memory_arbiter #(.STARVE_LIMIT(0)) dut_strict (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_fetch_req(i_fetch_req), .i_fetch_address(i_fetch_address),
        .o_fetch_ready(s_fetch_ready), .o_fetch_data(s_fetch_data),
        .i_data_req(i_data_req), .i_data_address(i_data_address), .i_data_rw(i_data_rw),
        .i_data_wdata(i_data_wdata), .o_data_ready(s_data_ready), .o_data_rdata(s_data_rdata),
        .o_mem_req(s_mem_req), .o_mem_address(s_mem_address), .o_mem_rw(s_mem_rw),
        .o_mem_wdata(s_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_debug_state(s_debug_state), .o_debug_grant_data(s_debug_grant_data)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        f_req;
        logic [15:0] f_addr;
        logic        d_req;
        logic [15:0] d_addr;
        logic        d_rw;
        logic [31:0] d_wdata;
        logic [31:0] mem_rdata;
        int          waits;
        logic        exp_grant_data;
        logic [15:0] exp_addr;
        logic        exp_rw;
        logic [31:0] exp_wdata;
        logic [31:0] exp_fetch_data;
        logic [31:0] exp_data_rdata;
    } vec_t;

    vec_t vecs [6];

    // Behavioural memory (driven by the responder) and the reference image the checks use.
    logic [31:0] mem_arr [0:65535];
    logic [31:0] ref_mem [0:65535];
    bit          rand_done;

    function automatic logic [31:0] init_word(input int a);
        logic [15:0] a16;
        a16 = 16'(a);
        return {~a16, a16};
    endfunction

    task automatic do_reset();
        i_reset_n = 1'b0;
        i_fetch_req = 1'b0;
        i_data_req = 1'b0;
        i_mem_ack = 1'b0;
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        int mreq_at, ready_at, f_cnt, d_cnt, unstable, left;
        bit acked;
        mreq_at = -1; ready_at = -1; f_cnt = 0; d_cnt = 0; unstable = 0;
        left = v.waits; acked = 0;
        @(negedge i_clk);
        i_fetch_req = v.f_req; i_fetch_address = v.f_addr;
        i_data_req = v.d_req; i_data_address = v.d_addr;
        i_data_rw = v.d_rw; i_data_wdata = v.d_wdata;
        for (int c = 1; c <= 12; c++) begin
            @(negedge i_clk);
            if (i_mem_ack) i_mem_ack = 1'b0;
            if (o_mem_req) begin
                if (mreq_at < 0) begin
                    mreq_at = c;
                    check($sformatf("v%0d_mem_address", idx), 32'(o_mem_address), 32'(v.exp_addr));
                    check($sformatf("v%0d_mem_rw", idx), 32'(o_mem_rw), 32'(v.exp_rw));
                    check($sformatf("v%0d_mem_wdata", idx), o_mem_wdata, v.exp_wdata);
                end else if (o_mem_address !== v.exp_addr || o_mem_rw !== v.exp_rw ||
                             o_mem_wdata !== v.exp_wdata) begin
                    unstable++;
                end
                if (!acked) begin
                    if (left == 0) begin
                        i_mem_ack = 1'b1;
                        i_mem_rdata = v.mem_rdata;
                        acked = 1;
                    end else begin
                        left--;
                    end
                end
            end
            if (o_fetch_ready) begin f_cnt++; if (ready_at < 0) ready_at = c; end
            if (o_data_ready)  begin d_cnt++; if (ready_at < 0) ready_at = c; end
            if (o_fetch_ready || o_data_ready) begin
                i_fetch_req = 1'b0;
                i_data_req = 1'b0;
            end
        end
        check($sformatf("v%0d_mem_req_latency", idx), 32'(mreq_at), 32'd1);
        check($sformatf("v%0d_ready_latency", idx), 32'(ready_at), 32'(2 + v.waits));
        check($sformatf("v%0d_mem_fields_stable", idx), 32'(unstable), 32'd0);
        check($sformatf("v%0d_fetch_ready_pulses", idx), 32'(f_cnt), v.exp_grant_data ? 32'd0 : 32'd1);
        check($sformatf("v%0d_data_ready_pulses", idx), 32'(d_cnt), v.exp_grant_data ? 32'd1 : 32'd0);
        check($sformatf("v%0d_grant_data", idx), 32'(o_debug_grant_data), 32'(v.exp_grant_data));
        check($sformatf("v%0d_fetch_data", idx), o_fetch_data, v.exp_fetch_data);
        check($sformatf("v%0d_data_rdata", idx), o_data_rdata, v.exp_data_rdata);
    endtask

    task automatic fetch_drv();
        int gap;
        bit got;
        for (int n = 0; n < N_RAND; n++) begin
            gap = $urandom_range(0, 2);
            got = 0;
            repeat (gap) @(negedge i_clk);
            i_fetch_address = 16'h0100 + 16'($urandom_range(0, 7));
            i_fetch_req = 1'b1;
            for (int t = 0; t < 200 && !got; t++) begin
                @(negedge i_clk);
                if (o_fetch_ready) got = 1;
            end
            if (got) check("rand_fetch_data", o_fetch_data, ref_mem[i_fetch_address]);
            else     check("rand_fetch_ready_timeout", 32'(o_fetch_ready), 32'd1);
            i_fetch_req = 1'b0;
        end
    endtask

    task automatic data_drv();
        int gap;
        bit got;
        for (int n = 0; n < N_RAND; n++) begin
            gap = $urandom_range(0, 2);
            got = 0;
            repeat (gap) @(negedge i_clk);
            i_data_address = 16'h0100 + 16'($urandom_range(0, 7));
            i_data_rw = 1'($urandom_range(0, 1));
            i_data_wdata = $urandom;
            i_data_req = 1'b1;
            for (int t = 0; t < 200 && !got; t++) begin
                @(negedge i_clk);
                if (o_data_ready) got = 1;
            end
            if (!got) begin
                check("rand_data_ready_timeout", 32'(o_data_ready), 32'd1);
            end else if (i_data_rw == RW_WRITE) begin
                check("rand_data_write_rdata", o_data_rdata, 32'd0);
                ref_mem[i_data_address] = i_data_wdata;
            end else begin
                check("rand_data_read", o_data_rdata, ref_mem[i_data_address]);
            end
            i_data_req = 1'b0;
        end
    endtask

    // Memory model: random 0..3 wait states, writes land when acknowledged.
    task automatic responder();
        int waits_left;
        waits_left = -1;
        while (!rand_done) begin
            @(negedge i_clk);
            if (i_mem_ack) begin
                i_mem_ack = 1'b0;
            end else if (o_mem_req) begin
                if (waits_left < 0) waits_left = $urandom_range(0, 3);
                if (waits_left == 0) begin
                    if (o_mem_rw == RW_WRITE) begin
                        mem_arr[o_mem_address] = o_mem_wdata;
                        i_mem_rdata = $urandom;
                    end else begin
                        i_mem_rdata = mem_arr[o_mem_address];
                    end
                    i_mem_ack = 1'b1;
                    waits_left = -1;
                end else begin
                    waits_left--;
                end
            end
        end
        i_mem_ack = 1'b0;
    endtask

    // Arbitration model: data first, unless the fetch has lost LIMIT times in a row.
    task automatic monitor();
        logic last_req, prev_f_rdy, prev_d_rdy, exp_d;
        int   losses;
        last_req = 0; prev_f_rdy = 0; prev_d_rdy = 0; losses = 0;
        while (!rand_done) begin
            @(posedge i_clk);
            #1;
            if (o_mem_req && !last_req) begin
                if (i_fetch_req && i_data_req) exp_d = (losses != LIMIT);
                else                           exp_d = i_data_req;
                if (i_fetch_req && exp_d) losses = (losses < LIMIT) ? losses + 1 : losses;
                else                      losses = 0;
                check("rand_grant_data", 32'(o_debug_grant_data), 32'(exp_d));
                check("rand_mem_address", 32'(o_mem_address),
                      32'(exp_d ? i_data_address : i_fetch_address));
                check("rand_mem_rw", 32'(o_mem_rw), 32'(exp_d ? i_data_rw : RW_READ));
                check("rand_mem_wdata", o_mem_wdata,
                      (exp_d && i_data_rw == RW_WRITE) ? i_data_wdata : 32'd0);
            end
            if (o_fetch_ready) check("rand_fetch_ready_single", {30'd0, prev_f_rdy, i_fetch_req}, 32'd1);
            if (o_data_ready)  check("rand_data_ready_single", {30'd0, prev_d_rdy, i_data_req}, 32'd1);
            last_req = o_mem_req;
            prev_f_rdy = o_fetch_ready;
            prev_d_rdy = o_data_ready;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, g1, losses, cnt_rdy, cnt_state;
        logic p0, p1, exp_d;
        bit got;

        vecs[0] = '{1'b1, 16'h0004, 1'b0, 16'h0000, RW_READ,  32'h0,        32'hDEADBEEF, 0,
                    1'b0, 16'h0004, RW_READ,  32'h0,        32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 16'h0010, RW_WRITE, 32'h12345678, 32'hFFFFFFFF, 3,
                    1'b1, 16'h0010, RW_WRITE, 32'h12345678, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 16'h0020, RW_READ,  32'h55555555, 32'hA5A50001, 1,
                    1'b1, 16'h0020, RW_READ,  32'h0,        32'hDEADBEEF, 32'hA5A50001};
        vecs[3] = '{1'b1, 16'h0030, 1'b1, 16'h0040, RW_READ,  32'h0,        32'h0BADF00D, 0,
                    1'b1, 16'h0040, RW_READ,  32'h0,        32'hDEADBEEF, 32'h0BADF00D};
        vecs[4] = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, RW_READ,  32'h0,        32'hFFFFFFFF, 2,
                    1'b0, 16'hFFFF, RW_READ,  32'h0,        32'hFFFFFFFF, 32'h0BADF00D};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 16'hFFFF, RW_WRITE, 32'hCAFEF00D, 32'h11111111, 0,
                    1'b1, 16'hFFFF, RW_WRITE, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h0};

        // Reset state
        repeat (2) @(negedge i_clk);
        check("reset_state", 32'(o_debug_state), 32'd0);
        check("reset_mem_req", 32'(o_mem_req), 32'd0);
        check("reset_readies", {30'd0, o_fetch_ready, o_data_ready}, 32'd0);
        check("reset_fetch_data", o_fetch_data, 32'd0);
        check("reset_data_rdata", o_data_rdata, 32'd0);
        check("reset_mem_fields", {15'd0, o_mem_address, o_mem_rw} | o_mem_wdata, 32'd0);
        check("reset_grant_data", 32'(o_debug_grant_data), 32'd0);
        do_reset();

        for (int i = 0; i < 6; i++) apply_vec(vecs[i], i);

        // Both ports held with an always-acking memory: grant pattern per limit.
        do_reset();
        i_mem_ack = 1'b1; i_mem_rdata = 32'h0;
        i_fetch_address = 16'h0300; i_fetch_req = 1'b1;
        i_data_address = 16'h0200; i_data_rw = RW_READ; i_data_req = 1'b1;
        g0 = 0; g1 = 0; p0 = 0; p1 = 0; losses = 0;
        for (int c = 0; c < 80 && (g0 < 15 || g1 < 15); c++) begin
            @(negedge i_clk);
            if (o_mem_req && !p0 && g0 < 15) begin
                exp_d = (losses != LIMIT);
                losses = exp_d ? losses + 1 : 0;
                check($sformatf("starve4_grant%0d", g0), 32'(o_debug_grant_data), 32'(exp_d));
                g0++;
            end
            if (s_mem_req && !p1 && g1 < 15) begin
                check($sformatf("strict_grant%0d", g1), 32'(s_debug_grant_data), 32'd1);
                g1++;
            end
            p0 = o_mem_req;
            p1 = s_mem_req;
        end
        check("starve4_grant_count", 32'(g0), 32'd15);
        check("strict_grant_count", 32'(g1), 32'd15);
        i_fetch_req = 1'b0; i_data_req = 1'b0; i_mem_ack = 1'b0;

        // Requests raised during RESPOND are not arbitrated until the next IDLE edge.
        do_reset();
        i_data_address = 16'h0050; i_data_rw = RW_WRITE; i_data_wdata = 32'h0F0F0F0F; i_data_req = 1'b1;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge i_clk);
            if (i_mem_ack) i_mem_ack = 1'b0;
            if (o_data_ready) got = 1;
            else if (o_mem_req) begin i_mem_ack = 1'b1; i_mem_rdata = 32'h0; end
        end
        check("respond_ready_seen", 32'(o_data_ready), 32'd1);
        check("respond_state_2", 32'(o_debug_state), 32'd2);
        i_fetch_address = 16'h0060; i_fetch_req = 1'b1;
        i_data_address = 16'h0068; i_data_rw = RW_READ;
        @(negedge i_clk);
        check("respond_state_0", 32'(o_debug_state), 32'd0);
        check("respond_no_grant", 32'(o_mem_req), 32'd0);
        @(negedge i_clk);
        check("respond_state_1", 32'(o_debug_state), 32'd1);
        check("respond_grant_data", 32'(o_debug_grant_data), 32'd1);
        check("respond_mem_address", 32'(o_mem_address), 32'h0068);
        i_mem_ack = 1'b1; i_mem_rdata = 32'h600D600D;
        @(negedge i_clk);
        check("respond_data_ready", 32'(o_data_ready), 32'd1);
        check("respond_data_rdata", o_data_rdata, 32'h600D600D);
        i_mem_ack = 1'b0; i_data_req = 1'b0; i_fetch_req = 1'b0;

        // Reset mid-ACCESS, then a late/spurious ack in IDLE.
        do_reset();
        @(negedge i_clk);
        i_fetch_address = 16'h0070; i_fetch_req = 1'b1;
        @(negedge i_clk);
        check("midreset_mem_req_before", 32'(o_mem_req), 32'd1);
        #2 i_reset_n = 1'b0;
        #1;
        check("midreset_mem_req_async", 32'(o_mem_req), 32'd0);
        check("midreset_state_async", 32'(o_debug_state), 32'd0);
        i_fetch_req = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h77777777;
        cnt_rdy = 0; cnt_state = 0;
        for (int t = 0; t < 4; t++) begin
            @(negedge i_clk);
            if (o_fetch_ready || o_data_ready) cnt_rdy++;
            if (o_debug_state != 2'd0) cnt_state++;
        end
        check("late_ack_ready_pulses", 32'(cnt_rdy), 32'd0);
        check("late_ack_state_changes", 32'(cnt_state), 32'd0);
        check("late_ack_fetch_data", o_fetch_data, 32'd0);
        i_mem_ack = 1'b0;

        // Randomized traffic against the memory and arbitration models.
        for (int a = 0; a < 65536; a++) begin
            mem_arr[a] = init_word(a);
            ref_mem[a] = init_word(a);
        end
        do_reset();
        rand_done = 0;
        fork
            begin
                fork
                    fetch_drv();
                    data_drv();
                join
                rand_done = 1;
            end
            monitor();
            responder();
        join

        repeat (4) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares one single-port 16-bit-address / 32-bit-data memory between the CPU's instruction-fetch port and its data-memory port, so that instruction and data memory can be one unified array. Sits between the CPU's instruction and data buses and the memory. Serialises accesses with a request/ready handshake on each side and a request/ack handshake toward memory. Data accesses have priority, with a bounded-starvation guarantee for fetch.

## Interface
- STARVE_LIMIT, 4, consecutive arbitration losses by a pending fetch before fetch is forced to win; 0 = strict data priority
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_fetch_req  in  1  fetch request; held until o_fetch_ready
- i_fetch_address  in  16  fetch address; stable while i_fetch_req high
- o_fetch_ready  out  1  one-cycle completion pulse
- o_fetch_data  out  32  instruction word captured at completion; holds until next fetch completion
- i_data_req  in  1  data request; held until o_data_ready
- i_data_address  in  16  data address
- i_data_rw  in  1  0 = read (RW_READ), 1 = write (RW_WRITE)
- i_data_wdata  in  32  write data
- o_data_ready  out  1  one-cycle completion pulse
- o_data_rdata  out  32  read data captured at completion; 0 after a write completion
- o_mem_req  out  1  memory request, registered
- o_mem_address  out  16  registered address
- o_mem_rw  out  1  registered direction
- o_mem_wdata  out  32  registered write data; 0 for reads
- i_mem_ack  in  1  memory completion, any number of cycles after o_mem_req rises (0 wait states allowed)
- i_mem_rdata  in  32  read data, valid when i_mem_ack high
- o_debug_state  out  2  FSM state
- o_debug_grant_data  out  1  1 = current/last grant is the data port

## Operation
- FSM: IDLE(0) -> ACCESS(1) -> RESPOND(2) -> IDLE. Encoding 3 is unused and recovers to IDLE.
- IDLE: if any request, grant and load o_mem_* at the edge, go to ACCESS.
  - Both requesting: data wins unless starve_count == STARVE_LIMIT and STARVE_LIMIT != 0, then fetch wins.
  - Fetch always issues as a read.
- starve_count (width clog2(STARVE_LIMIT+1), min 1):
  - increments when fetch requested and data was granted in IDLE;
  - clears when fetch is granted or i_fetch_req is low in IDLE;
  - saturates at STARVE_LIMIT.
- ACCESS: o_mem_req high. On an edge with i_mem_ack high:
  - capture i_mem_rdata into the granted port's data output (data port writes capture 0);
  - drop o_mem_req;
  - go to RESPOND.
  - Other port's output register is unchanged.
- RESPOND: the granted port's ready is high for exactly this cycle; no arbitration this cycle. Requests held high here are ignored and are evaluated again in the next IDLE.
- i_mem_ack outside ACCESS is ignored.
- Reset (asynchronous, any state, including mid-ACCESS): state IDLE, all outputs 0, starve_count 0, o_debug_grant_data 0. An abandoned memory transaction is not completed.

## Timing
- Request sampled high at edge k, with a zero-wait memory (ack in first ACCESS cycle):
  - o_mem_req high in cycle k..k+1;
  - ready high in cycle k+1..k+2.
  - The transaction occupies 3 cycles including IDLE.
- Each memory wait state adds one cycle.
- Back-to-back single requester, zero-wait: one completion every 3 cycles.
- o_mem_* are stable for the whole ACCESS period.
- All outputs are registered; none depend combinationally on inputs.

## Structure
- Shared package: RW_READ/RW_WRITE, ARB_IDLE/ARB_ACCESS/ARB_RESPOND encodings, ADDR_W=16, DATA_W=32. The CPU's data-bus RW constants move to this package too.
- One sub-module: starve_counter, a saturating counter with inc/clear/at_limit, parameterised by STARVE_LIMIT.

## Test plan
- Fetch only at 0x0004, memory returns 0xDEADBEEF with 0 waits -> o_mem_req cycle k+1, o_fetch_ready and o_fetch_data=0xDEADBEEF cycle k+2, o_data_ready never high.
- Data write 0x0010←0x12345678, 3 wait states -> o_mem_rw=1, o_mem_wdata stable for 4 cycles, o_data_ready 1 pulse, o_data_rdata=0.
- Both held continuously, STARVE_LIMIT=4 -> grants data,data,data,data,fetch, repeating; STARVE_LIMIT=0 -> fetch never granted while data is held.
- Simultaneous request arriving in the RESPOND cycle -> no grant that cycle; grant at the next IDLE evaluation; o_debug_state sequence is 2,0,1.
- i_reset_n low mid-ACCESS -> o_mem_req drops immediately without a clock edge; a late i_mem_ack after reset produces no ready pulse.
- Spurious i_mem_ack in IDLE -> no state change, no ready pulse.
